// File: rtl/keyup_event_capture.sv
// rtl/keyup_event_capture.sv - qualifies minmax_filter 'triggered' into timestamped key-up events
//
// Purpose: counts sample strobes, evaluates 'triggered' TRIG_LATENCY clocks after
// each strobe, confirms a key-up after CONFIRM_SAMPLES consecutive high samples,
// re-arms after RELEASE_SAMPLES consecutive low samples, and queues the index of
// the first high sample of each confirmed run in a FIFO read out as a stream.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   axiiv      sample strobe (same strobe as the filter)
//   triggered  level output of the filter
//   axiod      timestamp at FIFO head (registered)
//   axiov      FIFO non-empty
//   axior      downstream ready; pop on axiov && axior
//   overflow   sticky: an event was dropped on a full FIFO
//   busy       FSM not idle

module keyup_event_capture #(
    parameter int TS_WIDTH        = 32,
    parameter int CONFIRM_SAMPLES = 4,
    parameter int RELEASE_SAMPLES = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int TRIG_LATENCY    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                axiiv,
    input  logic                triggered,
    output logic [TS_WIDTH-1:0] axiod,
    output logic                axiov,
    input  logic                axior,
    output logic                overflow,
    output logic                busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = $clog2(CONFIRM_SAMPLES + 1);
    localparam int LW = $clog2(RELEASE_SAMPLES + 1);
    localparam logic [HW-1:0] HMAX = HW'(CONFIRM_SAMPLES);
    localparam logic [LW-1:0] LMAX = LW'(RELEASE_SAMPLES);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Sample counter and strobe/tag delay line
    logic [TS_WIDTH-1:0]     sample_cnt;
    logic [TRIG_LATENCY-1:0] vld_pipe;
    logic [TS_WIDTH-1:0]     tag_pipe [TRIG_LATENCY];
    logic                    eval_vld;
    logic [TS_WIDTH-1:0]     eval_tag;

    // Each strobe carries its own tag down the line so back-to-back strobes
    // closer than the trigger latency are each evaluated with the right index.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
            vld_pipe   <= '0;
            for (int i = 0; i < TRIG_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            if (axiiv) begin
                sample_cnt <= sample_cnt + TS_WIDTH'(1);
            end
            vld_pipe[0] <= axiiv;
            tag_pipe[0] <= sample_cnt;
            for (int i = 1; i < TRIG_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign eval_vld = vld_pipe[TRIG_LATENCY-1];
    assign eval_tag = tag_pipe[TRIG_LATENCY-1];

    // FSM
    state_t              state, state_nxt;
    logic [HW-1:0]       hcnt, hcnt_nxt;
    logic [LW-1:0]       lcnt, lcnt_nxt;
    logic [TS_WIDTH-1:0] cand_ts, cand_nxt;
    logic                push;
    logic [TS_WIDTH-1:0] push_ts;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            hcnt    <= '0;
            lcnt    <= '0;
            cand_ts <= '0;
        end else begin
            state   <= state_nxt;
            hcnt    <= hcnt_nxt;
            lcnt    <= lcnt_nxt;
            cand_ts <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        lcnt_nxt  = lcnt;
        cand_nxt  = cand_ts;
        if (eval_vld) begin
            case (state)
                IDLE: begin
                    if (triggered) begin
                        if (CONFIRM_SAMPLES == 1) begin
                            state_nxt = HOLD;
                            lcnt_nxt  = '0;
                        end else begin
                            state_nxt = CONFIRM;
                            cand_nxt  = eval_tag;
                            hcnt_nxt  = HW'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if (!triggered) begin
                        state_nxt = IDLE;
                    end else if (hcnt + HW'(1) == HMAX) begin
                        state_nxt = HOLD;
                        lcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
                HOLD: begin
                    if (triggered) begin
                        lcnt_nxt = '0;
                    end else if (lcnt + LW'(1) == LMAX) begin
                        state_nxt = IDLE;
                    end else begin
                        lcnt_nxt = lcnt + LW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The timestamp pushed is the first high sample of the run, not the
    // confirming one; only a single-sample confirm uses the current tag.
    always_comb begin
        busy    = (state != IDLE);
        push    = 1'b0;
        push_ts = cand_ts;
        if (eval_vld && triggered) begin
            case (state)
                IDLE: begin
                    if (CONFIRM_SAMPLES == 1) begin
                        push    = 1'b1;
                        push_ts = eval_tag;
                    end
                end
                CONFIRM: begin
                    if (hcnt + HW'(1) == HMAX) begin
                        push = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Event FIFO
    logic [TS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr, rd_nxt;
    logic [AW:0]         count, count_nxt;
    logic                full, pop, wr_en;

    assign full   = (count == FULL_CNT);
    assign pop    = axiov && axior;
    assign wr_en  = push && (!full || pop);
    assign rd_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (wr_en && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (!wr_en && pop) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_ts;
        end
    end

    // axiod is preloaded with the next head; when the entry being written now
    // becomes the head, it bypasses the memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            axiov    <= 1'b0;
            axiod    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            axiov  <= (count_nxt != '0);
            axiod  <= (wr_en && (wr_ptr == rd_nxt)) ? push_ts : mem[rd_nxt];
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keyup_event_capture.sv
// tb/tb_keyup_event_capture.sv - scoreboard bench for keyup_event_capture

module tb_keyup_event_capture;

    localparam int CONF  = 4;
    localparam int REL   = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, axiiv, triggered, axior;
    logic [31:0] axiod;
    logic        axiov, overflow, busy;
    logic [7:0]  axiod8;
    logic        axiov8, overflow8, busy8;

    always #5 clk = ~clk;

    keyup_event_capture #(.TS_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .triggered(triggered),
        .axiod(axiod), .axiov(axiov), .axior(axior),
        .overflow(overflow), .busy(busy)
    );

    keyup_event_capture #(.TS_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .axiiv(axiiv), .triggered(triggered),
        .axiod(axiod8), .axiov(axiov8), .axior(axior),
        .overflow(overflow8), .busy(busy8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus ----------------
    bit lvl_q[$];          // intended level of each issued sample
    bit pend_valid = 0;
    bit pend_lvl   = 0;
    int stim_idx   = 0;    // index of the next sample to issue
    int axior_mode = 0;    // 0 low, 1 high, 2 toggle, 3 random

    task automatic drive_cycle(input bit iv, input bit lvl);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        axiiv = iv;
        // outside its evaluation cycle 'triggered' is noise the DUT must ignore
        triggered = pend_valid ? pend_lvl : 1'($urandom);
        pend_valid = iv;
        pend_lvl   = lvl;
        if (iv) begin
            lvl_q.push_back(lvl);
            stim_idx++;
        end
        case (axior_mode)
            0: axior = 1'b0;
            1: axior = 1'b1;
            2: axior = ~axior;
            default: axior = 1'($urandom);
        endcase
    endtask

    task automatic sample(input bit lvl);
        drive_cycle(1'b1, lvl);
        repeat ($urandom_range(0, 2)) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic run(input int start, input int len);
        while (stim_idx < start) sample(1'b0);
        repeat (len) sample(1'b1);
    endtask

    task automatic lows(input int n);
        repeat (n) sample(1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        axiiv      = 1'b0;
        triggered  = 1'($urandom);
        pend_valid = 0;
        stim_idx   = 0;
    endtask

    // ---------------- reference model ----------------
    // Event rule: a high run of length >= CONF starting while armed yields one
    // event stamped with the run's first sample; arming returns after REL
    // consecutive low samples following the event.
    typedef struct { bit lvl; int idx; } ev_t;
    bit          ev_pend = 0;
    ev_t         ev_cur;
    int          k = 0;
    bit          armed = 1;
    int          run_len = 0, run_start = 0, low_cnt = 0;
    int          mcount = 0;
    bit          exp_ovf = 0, exp_busy = 0;
    logic [31:0] q32[$];
    logic [7:0]  q8[$];
    int          n_acc = 0;
    bit          m_pop, m_ev;
    int          m_ts;

    always @(posedge clk) begin
        if (rst) begin
            ev_pend = 0; k = 0; armed = 1; run_len = 0; low_cnt = 0;
            mcount = 0; exp_ovf = 0; exp_busy = 0;
            q32.delete(); q8.delete(); lvl_q.delete();
        end else begin
            m_pop = (mcount > 0) && axior;
            m_ev  = 0;
            m_ts  = 0;
            if (ev_pend) begin
                if (ev_cur.lvl) begin
                    if (run_len == 0) run_start = ev_cur.idx;
                    run_len++;
                    low_cnt = 0;
                    if (armed && run_len == CONF) begin
                        m_ev  = 1;
                        m_ts  = run_start;
                        armed = 0;
                    end
                end else begin
                    run_len = 0;
                    low_cnt++;
                    if (!armed && low_cnt >= REL) armed = 1;
                end
            end
            if (axiiv) begin
                ev_pend    = 1;
                ev_cur.lvl = lvl_q.pop_front();
                ev_cur.idx = k;
                k++;
            end else begin
                ev_pend = 0;
            end
            if (m_ev) begin
                if (mcount == DEPTH && !m_pop) begin
                    exp_ovf = 1;
                end else begin
                    q32.push_back(32'(m_ts));
                    q8.push_back(8'(m_ts));
                    mcount++;
                    n_acc++;
                end
            end
            if (m_pop) mcount--;
            exp_busy = !armed || (run_len > 0);
        end
    end

    // ---------------- monitor ----------------
    bit mon_on = 0;
    int n_pop  = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            check("axiov", axiov, mcount != 0);
            check("axiov8", axiov8, mcount != 0);
            check("overflow", overflow, exp_ovf);
            check("overflow8", overflow8, exp_ovf);
            check("busy", busy, exp_busy);
            check("busy8", busy8, exp_busy);
            if (!rst && axiov && axior) begin
                n_pop++;
                if (q32.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop32: DUT presented %0d with no expected entry", axiod);
                end else begin
                    check("axiod", axiod, q32.pop_front());
                end
            end
            if (!rst && axiov8 && axior) begin
                if (q8.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop8: DUT presented %0d with no expected entry", axiod8);
                end else begin
                    check("axiod8", axiod8, q8.pop_front());
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    int base;

    initial begin
        rst = 1'b1; axiiv = 1'b0; triggered = 1'b0; axior = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_axiov", axiov, 0);
        check("rst_axiod", axiod, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_axiod8", axiod8, 0);
        mon_on = 1;

        // 1: single qualified run
        axior_mode = 1;
        base = n_pop;
        run(100, 50); lows(20);
        check("t1_events", n_pop - base, 1);

        // 2: too-short run
        base = n_pop;
        run(200, 3); lows(20);
        check("t2_events", n_pop - base, 0);
        check("t2_busy", busy, 0);

        // 3: re-trigger rejection and re-arm
        base = n_pop;
        run(300, 20); run(330, 20); lows(20);
        check("t3a_events", n_pop - base, 1);
        base = n_pop;
        run(400, 20); run(440, 20); lows(20);
        check("t3b_events", n_pop - base, 2);

        // 4: overflow with consumer stalled, then drain
        axior_mode = 0;
        base = n_pop;
        for (int i = 0; i < 9; i++) run(1000 + 100 * i, 5);
        lows(20);
        check("t4_overflow", overflow, 1);
        check("t4_stalled", n_pop - base, 0);
        axior_mode = 1;
        lows(20);
        check("t4_drained", n_pop - base, DEPTH);
        check("t4_axiov", axiov, 0);

        // 5: reset mid-confirm, then counter restarts
        do_reset();
        run(500, 2);
        base = n_pop;
        do_reset();
        lows(4);
        check("t5_no_event", n_pop - base, 0);
        check("t5_overflow_clr", overflow, 0);
        run(7, 6); lows(20);
        check("t5_events", n_pop - base, 1);

        // 6: 8-bit wrap, then randomized runs with toggling/random ready
        base = n_pop;
        run(260, 5); lows(20);
        check("t6_wrap_events", n_pop - base, 1);
        for (int ph = 0; ph < 2; ph++) begin
            axior_mode = 2 + ph;
            for (int r = 0; r < 60; r++) begin
                repeat ($urandom_range(1, 8)) sample(1'b1);
                repeat ($urandom_range(1, 25)) sample(1'b0);
            end
        end
        axior_mode = 1;
        lows(40);
        check("final_count", n_pop, n_acc);
        check("final_queue", q32.size(), 0);
        check("final_axiov", axiov, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
